// File: rtl/pio_mem_mux.sv
// PIO target multiplexer fanning one slave port out to NUM_CH table memories.
// Optional BUSY timeout is compiled in with `define PIO_MUX_TIMEOUT_EN.
module pio_mem_mux #(
   parameter int              NUM_CH      = 4,
   parameter int              PIO_NBITS   = 32,
   parameter int              SEL_LSB     = 16,
   parameter int              SEL_NBITS   = 3,
   parameter int              TIMEOUT_CYC = 64,
   parameter logic [31:0]     ERR_DATA    = 32'hDEAD_BEEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clk_div,
   input  logic                        reg_bs,
   input  logic                        reg_wr,
   input  logic                        reg_rd,
   input  logic [PIO_NBITS-1:0]        reg_addr,
   input  logic [NUM_CH-1:0]           mem_ack,
   input  logic [NUM_CH*PIO_NBITS-1:0] mem_rdata,
   output logic [NUM_CH-1:0]           reg_ms,
   output logic                        pio_ack,
   output logic                        pio_rvalid,
   output logic [PIO_NBITS-1:0]        pio_rdata,
   output logic                        pio_err,
   output logic [7:0]                  err_cnt
);

   localparam logic [PIO_NBITS-1:0] ERR_WORD = PIO_NBITS'(ERR_DATA);

   if (NUM_CH < 1 || NUM_CH > 8 || (1 << SEL_NBITS) < NUM_CH ||
       TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_cfg
      $error("pio_mem_mux: illegal parameter set");
   end

   typedef enum logic [2:0] {
      IDLE,
      BUSY,
      UNMAP,
      DONE,
      RESP
   } state_t;

   state_t                state;
   state_t                state_nx;
   logic [SEL_NBITS-1:0]  idx;
   logic [SEL_NBITS-1:0]  idx_in;
   logic                  is_rd;
   logic                  err;
   logic [PIO_NBITS-1:0]  hold;
   logic                  req;
   logic                  sel_ok;
   logic                  ack_hit;
   logic [PIO_NBITS-1:0]  rdata_sel;
   logic                  to_hit;
   logic                  unused_addr;

   assign idx_in      = reg_addr[SEL_LSB +: SEL_NBITS];
   assign req         = reg_bs & (reg_rd | reg_wr);
   assign sel_ok      = 32'(idx_in) < NUM_CH;
   assign unused_addr = ^reg_addr;

   // Only the latched channel may complete the access.
   always_comb begin
      ack_hit   = 1'b0;
      rdata_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (32'(idx) == i) begin
            ack_hit   = mem_ack[i];
            rdata_sel = mem_rdata[i*PIO_NBITS +: PIO_NBITS];
         end
      end
   end

`ifdef PIO_MUX_TIMEOUT_EN
   logic [7:0] tcnt;

   assign to_hit = (tcnt == 8'(TIMEOUT_CYC));

   always_ff @(posedge clk) begin
      if (rst)
         tcnt <= '0;
      else if (state == IDLE)
         tcnt <= '0;
      else if (state == BUSY && clk_div)
         tcnt <= tcnt + 8'd1;
   end
`else
   assign to_hit = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (req) state_nx = sel_ok ? BUSY : UNMAP;
         BUSY:    if (ack_hit || to_hit) state_nx = DONE;
         UNMAP:   state_nx = DONE;
         DONE:    if (clk_div) state_nx = RESP;
         RESP:    if (clk_div) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         is_rd      <= 1'b0;
         err        <= 1'b0;
         hold       <= '0;
         reg_ms     <= '0;
         pio_ack    <= 1'b0;
         pio_rvalid <= 1'b0;
         pio_rdata  <= '0;
         pio_err    <= 1'b0;
         err_cnt    <= '0;
      end else begin
         state <= state_nx;
         unique case (state)
            IDLE: begin
               if (req) begin
                  idx   <= idx_in;
                  is_rd <= reg_rd;
                  if (sel_ok) reg_ms <= NUM_CH'(1) << idx_in;
               end
            end
            BUSY: begin
               if (ack_hit) begin
                  hold   <= rdata_sel;
                  err    <= 1'b0;
                  reg_ms <= '0;
               end else if (to_hit) begin
                  hold   <= ERR_WORD;
                  err    <= 1'b1;
                  reg_ms <= '0;
               end
            end
            UNMAP: begin
               hold <= ERR_WORD;
               err  <= 1'b1;
            end
            DONE: begin
               if (clk_div) begin
                  pio_ack    <= 1'b1;
                  pio_rvalid <= is_rd;
                  pio_rdata  <= is_rd ? hold : '0;
                  pio_err    <= err;
                  if (err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
               end
            end
            RESP: begin
               if (clk_div) begin
                  pio_ack    <= 1'b0;
                  pio_rvalid <= 1'b0;
                  pio_rdata  <= '0;
                  pio_err    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pio_mem_mux.sv
// Randomised bench for pio_mem_mux with a transaction-level reference model.
// Timeout checks follow `define PIO_MUX_TIMEOUT_EN like the design.
module tb_pio_mem_mux;

   localparam int NC = 4;
   localparam int W  = 32;
   localparam int SL = 16;
   localparam int SN = 3;
   localparam logic [W-1:0] ERRW = 32'hDEAD_BEEF;

   logic            clk = 1'b0;
   logic            rst;
   logic            clk_div;
   logic            reg_bs;
   logic            reg_wr;
   logic            reg_rd;
   logic [W-1:0]    reg_addr;
   logic [NC-1:0]   mem_ack;
   logic [NC*W-1:0] mem_rdata;
   logic [NC-1:0]   reg_ms;
   logic            pio_ack;
   logic            pio_rvalid;
   logic [W-1:0]    pio_rdata;
   logic            pio_err;
   logic [7:0]      err_cnt;

   int n_vec  = 0;
   int n_bad  = 0;
   int exp_cnt = 0;
   bit div_hi = 1'b0;

   pio_mem_mux #(
      .NUM_CH(NC), .PIO_NBITS(W), .SEL_LSB(SL), .SEL_NBITS(SN),
      .TIMEOUT_CYC(4), .ERR_DATA(32'hDEAD_BEEF)
   ) dut (
      .clk(clk), .rst(rst), .clk_div(clk_div), .reg_bs(reg_bs),
      .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .reg_ms(reg_ms),
      .pio_ack(pio_ack), .pio_rvalid(pio_rvalid), .pio_rdata(pio_rdata),
      .pio_err(pio_err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #800_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic pick_div();
      return div_hi ? 1'b1 : ($urandom_range(0, 2) == 0);
   endfunction

   task automatic scramble_rdata();
      for (int c = 0; c < NC; c++) mem_rdata[c*W +: W] = $urandom;
   endtask

   task automatic request(input bit rd, input bit wr, input int idx);
      logic [SN-1:0] f;
      f = idx[SN-1:0];
      reg_bs   = 1'b1;
      reg_rd   = rd;
      reg_wr   = wr;
      reg_addr = $urandom;
      reg_addr[SL +: SN] = f;
      mem_ack  = '0;
      clk_div  = pick_div();
   endtask

   // Waits for the response strobe, checks it, then checks its release.
   task automatic respond(input bit isrd, input logic [W-1:0] ed,
                          input bit eerr);
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < 200 && !seen; t++) begin
         clk_div = pick_div();
         @(negedge clk);
         if (clk_div) seen = 1'b1;
         else check("ack_wait", W'(pio_ack), 0);
      end
      if (!seen) check("ack_bound", 0, 1);
      if (eerr && exp_cnt < 255) exp_cnt++;
      check("ack", W'(pio_ack), 1);
      check("rvalid", W'(pio_rvalid), W'(isrd));
      check("rdata", pio_rdata, ed);
      check("err", W'(pio_err), W'(eerr));
      check("err_cnt", W'(err_cnt), W'(exp_cnt));
      seen = 1'b0;
      for (int t = 0; t < 200 && !seen; t++) begin
         clk_div = pick_div();
         @(negedge clk);
         if (clk_div) seen = 1'b1;
         else check("ack_hold", W'(pio_ack), 1);
      end
      check("ack_clr", W'(pio_ack), 0);
      check("rdata_clr", pio_rdata, 0);
      clk_div = 1'b0;
   endtask

   task automatic txn(input bit rd, input bit wr, input int idx,
                      input int delay, input logic [W-1:0] data);
      logic [NC-1:0] oh;
      bit            mapped;
      mapped = idx < NC;
      oh = mapped ? (NC'(1) << idx) : '0;
      request(rd, wr, idx);
      @(negedge clk);
      reg_rd = 1'b0;
      reg_wr = 1'b0;
      reg_bs = 1'b0;
      check("ms_start", W'(reg_ms), W'(oh));
      if (mapped) begin
         for (int k = 0; k < delay; k++) begin
            clk_div  = pick_div();
            mem_ack  = NC'($urandom) & ~oh;
            reg_bs   = 1'b1;
            reg_rd   = 1'($urandom);
            reg_addr = $urandom;
            scramble_rdata();
            @(negedge clk);
            check("ms_hold", W'(reg_ms), W'(oh));
         end
         reg_bs  = 1'b0;
         reg_rd  = 1'b0;
         clk_div = pick_div();
         mem_ack = oh | (NC'($urandom) & ~oh);
         scramble_rdata();
         mem_rdata[idx*W +: W] = data;
         @(negedge clk);
         mem_ack = '0;
         check("ms_drop", W'(reg_ms), 0);
         respond(rd, rd ? data : '0, 1'b0);
      end else begin
         clk_div = pick_div();
         @(negedge clk);
         check("ms_unmap", W'(reg_ms), 0);
         respond(rd, rd ? ERRW : '0, 1'b1);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 0;
      check("rst_ms", W'(reg_ms), 0);
      check("rst_ack", W'(pio_ack), 0);
      check("rst_rvalid", W'(pio_rvalid), 0);
      check("rst_rdata", pio_rdata, 0);
      check("rst_err", W'(pio_err), 0);
      check("rst_cnt", W'(err_cnt), 0);
   endtask

   initial begin
      bit rd;
      bit wr;
      bit got_ack;
      rst = 1'b1;
      clk_div = 1'b0;
      reg_bs = 1'b0;
      reg_wr = 1'b0;
      reg_rd = 1'b0;
      reg_addr = '0;
      mem_ack = '0;
      mem_rdata = '0;
      @(negedge clk);
      do_reset();

      txn(1'b1, 1'b0, 2, 3, 32'h1234_5678);
      txn(1'b0, 1'b1, 0, 1, $urandom);
      txn(1'b1, 1'b0, 6, 0, $urandom);
      txn(1'b1, 1'b1, 3, 0, $urandom);
      div_hi = 1'b1;
      txn(1'b1, 1'b0, 1, 2, $urandom);
      txn(1'b0, 1'b1, 5, 0, $urandom);
      div_hi = 1'b0;

      for (int n = 0; n < 150; n++) begin
         rd = 1'($urandom);
         wr = rd ? 1'($urandom) : 1'b1;
         div_hi = ($urandom_range(0, 3) == 0);
         txn(rd, wr, $urandom_range(0, 7), $urandom_range(0, 5), $urandom);
      end
      div_hi = 1'b0;

`ifdef PIO_MUX_TIMEOUT_EN
      request(1'b1, 1'b0, 1);
      clk_div = 1'b0;
      @(negedge clk);
      reg_bs = 1'b0;
      reg_rd = 1'b0;
      for (int k = 0; k < 4; k++) begin
         clk_div = 1'b1;
         @(negedge clk);
         check("to_ms_hold", W'(reg_ms), 2);
      end
      @(negedge clk);
      check("to_ms_drop", W'(reg_ms), 0);
      respond(1'b1, ERRW, 1'b1);
`else
      request(1'b1, 1'b0, 1);
      @(negedge clk);
      reg_bs = 1'b0;
      reg_rd = 1'b0;
      got_ack = 1'b0;
      for (int k = 0; k < 100; k++) begin
         clk_div = 1'b1;
         @(negedge clk);
         if (pio_ack) got_ack = 1'b1;
      end
      clk_div = 1'b0;
      check("noack_100", W'(got_ack), 0);
      check("noack_ms", W'(reg_ms), 2);
`endif

      request(1'b1, 1'b0, 1);
      clk_div = 1'b0;
      @(negedge clk);
      reg_bs = 1'b0;
      reg_rd = 1'b0;
      @(negedge clk);
      check("pre_rst_ms", W'(reg_ms), 2);
      do_reset();
      got_ack = 1'b0;
      for (int k = 0; k < 6; k++) begin
         clk_div = 1'b1;
         @(negedge clk);
         if (pio_ack) got_ack = 1'b1;
      end
      clk_div = 1'b0;
      check("rst_noresp", W'(got_ack), 0);
      txn(1'b1, 1'b0, 1, 2, $urandom);

      div_hi = 1'b1;
      for (int n = 0; n < 300; n++)
         txn(1'($urandom), 1'b1, $urandom_range(4, 7), 0, $urandom);
      check("sat_cnt", W'(err_cnt), 255);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
